phase_clock_divider: RTL and testbench
======================================

PHASE_CLOCK_DIVIDER -- requirements
Module: phase_clock_divider

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 3, meaning the number of independent divider channels (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the width of each channel's divisor and counter.
REQ-003 The module SHALL have parameter NUM_PH, default 4, meaning the width of the one-hot phase sequencer (2..16).
REQ-004 clkIn  input  1  single clock; all state is updated on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clkIn.
REQ-006 enable  input  1  global count enable; low freezes all channels and the sequencer.
REQ-007 divVal  input  NUM_CH*CNT_W  per-channel divisor; channel i uses bits [i*CNT_W +: CNT_W].
REQ-008 clkOut  output  NUM_CH  registered divided clocks, one per channel.
REQ-009 tick  output  NUM_CH  registered one-cycle terminal-count pulses, one per channel.
REQ-010 phaseOut  output  NUM_PH  registered one-hot phase vector, advanced by channel 0.

Function
REQ-011 Each channel SHALL hold a CNT_W-bit counter cnt[i] and a CNT_W-bit effective divisor div[i]; div value 0 is treated as 1.
REQ-012 With enable high, a channel is at terminal count when cnt[i] >= div[i]-1; the comparison uses >= so that a divisor reduced below the current count wraps immediately.
REQ-013 At terminal count with enable high, the next edge SHALL set cnt[i]=0, set tick[i]=1 and toggle clkOut[i]; otherwise cnt[i] increments and tick[i]=0.
REQ-014 A steady divisor d SHALL give tick[i] period d cycles, and clkOut[i] period 2d cycles at exactly 50% duty; d=1 gives tick stuck at 1 and clkOut toggling every cycle.
REQ-015 The latency from the first enabled edge after reset to the first tick[i]=1 SHALL be d edges.
REQ-016 With enable low, cnt, clkOut and phaseOut SHALL hold their values, and tick SHALL be 0 on the next edge.
REQ-017 phaseOut SHALL rotate left by one position (MSB wraps to bit 0) on every edge where channel 0 is at terminal count with enable high.
REQ-018 Channels SHALL be fully independent; simultaneous terminal counts SHALL each be handled in the same cycle.
REQ-019 Counter arithmetic SHALL be CNT_W bits wide and SHALL never overflow, because the terminal compare precedes any increment.

Reset
REQ-020 When reset is high on an edge, the next values SHALL be: cnt=0, tick=0, clkOut=0, phaseOut=1 (bit 0 set), and div[i] loaded from divVal; reset overrides enable.
REQ-021 Reset asserted mid-period SHALL discard the partial count with no extra tick; counting SHALL restart from 0 on the first enabled edge after reset is released.

Configuration
REQ-022 The macro SHALL be named PHASE_DIV_SHADOW_LOAD_EN.
REQ-023 With PHASE_DIV_SHADOW_LOAD_EN defined, div[i] SHALL be loaded from divVal only at reset and on edges where channel i is at terminal count, giving glitch-free period changes.
REQ-024 With PHASE_DIV_SHADOW_LOAD_EN undefined, div[i] SHALL follow divVal every cycle, with the wrap behaviour given in REQ-012.

Verification
REQ-025 divVal ch0=3, ch1=1, ch2=4, enable=1 after reset: tick0 every 3rd cycle; clkOut0 period 6; tick1 stuck at 1 and clkOut1 toggling every cycle; clkOut2 period 8.
REQ-026 NUM_PH=4, ch0=2, 8 enabled cycles: phaseOut follows 0001, 0010, 0100, 1000, 0001, changing every 2 cycles.
REQ-027 enable dropped for 5 cycles when cnt0=1 (ch0=3): tick0=0, clkOut0 and phaseOut held; after resume, the next tick0 arrives 2 cycles later.
REQ-028 ch0 divVal changed from 8 to 2 while cnt0=5: with the macro defined, tick0 at cnt0=7, then every 2 cycles; without it, tick0 on the next edge, then every 2 cycles.
REQ-029 reset pulsed for one cycle mid-period: all outputs go to their reset values on the next edge; first tick0 arrives exactly d cycles after release.
REQ-030 divVal ch0=0: behaves identically to divisor 1.

Source files
------------

// File: rtl/phase_clock_divider.sv
// phase_clock_divider
//   Multi-channel integer clock divider with a one-hot phase sequencer.
//   Each channel counts enabled cycles up to its divisor, emits a one-cycle
//   terminal-count pulse and toggles a 50% duty divided clock. Channel 0's
//   terminal count also rotates a one-hot phase vector.
//
// Ports
//   clkIn     in   1              single clock, rising edge
//   reset     in   1              synchronous active-high reset
//   enable    in   1              global count enable (low freezes everything)
//   divVal    in   NUM_CH*CNT_W   per-channel divisor, channel i at [i*CNT_W +: CNT_W]
//   clkOut    out  NUM_CH         registered divided clocks
//   tick      out  NUM_CH         registered terminal-count pulses
//   phaseOut  out  NUM_PH         registered one-hot phase vector
//
// Configuration
//   PHASE_DIV_SHADOW_LOAD_EN  when defined, each channel's divisor is captured
//                             only at reset and at that channel's terminal
//                             count, so period changes take effect cleanly at
//                             the next period boundary. When undefined, the
//                             divisor follows divVal every cycle.

module phase_clock_divider #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned NUM_PH = 4
) (
    input  logic                      clkIn,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH*CNT_W-1:0]   divVal,
    output logic [NUM_CH-1:0]         clkOut,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_PH-1:0]         phaseOut
);

    // Per-channel counters
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    // Divisor as presented on divVal, with 0 promoted to 1
    logic [NUM_CH-1:0][CNT_W-1:0] divNorm_c;

    // Divisor actually used for the terminal-count compare
    logic [NUM_CH-1:0][CNT_W-1:0] divCur_c;

    // Terminal count per channel (already qualified by enable)
    logic [NUM_CH-1:0]            termCount_c;

    // Normalise the raw divisors
    always_comb begin
        divNorm_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            divNorm_c[i] = divVal[i*CNT_W +: CNT_W];
            if (divNorm_c[i] == '0) begin
                divNorm_c[i] = CNT_W'(1);
            end
        end
    end

`ifdef PHASE_DIV_SHADOW_LOAD_EN
    // Shadowed divisors, reloaded only at a period boundary
    logic [NUM_CH-1:0][CNT_W-1:0] divReg;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            divReg <= divNorm_c;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (termCount_c[i]) begin
                    divReg[i] <= divNorm_c[i];
                end
            end
        end
    end

    always_comb begin
        divCur_c = divReg;
    end
`else
    // Divisor tracks the input directly
    always_comb begin
        divCur_c = divNorm_c;
    end
`endif

    // Terminal-count detect; >= lets a shrunken divisor wrap at once
    always_comb begin
        termCount_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            termCount_c[i] = enable && (cnt[i] >= (divCur_c[i] - CNT_W'(1)));
        end
    end

    // Counters, ticks and divided clocks
    always_ff @(posedge clkIn) begin
        if (reset) begin
            cnt    <= '0;
            tick   <= '0;
            clkOut <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (termCount_c[i]) begin
                    cnt[i]    <= '0;
                    tick[i]   <= 1'b1;
                    clkOut[i] <= ~clkOut[i];
                end else if (enable) begin
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

    // One-hot phase sequencer stepped by channel 0
    always_ff @(posedge clkIn) begin
        if (reset) begin
            phaseOut <= NUM_PH'(1);
        end else if (termCount_c[0]) begin
            phaseOut <= {phaseOut[NUM_PH-2:0], phaseOut[NUM_PH-1]};
        end
    end

endmodule

// File: tb/tb_phase_clock_divider.sv
// Self-checking bench for phase_clock_divider: directed scenarios with fixed
// expectations plus randomized traffic, all compared against a behavioural
// model that tracks counts of elapsed cycles and ticks per channel.

module tb_phase_clock_divider;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_PH = 4;
    localparam int unsigned DV_W   = NUM_CH * CNT_W;

    logic              clkIn;
    logic              reset;
    logic              enable;
    logic [DV_W-1:0]   divVal;
    logic [NUM_CH-1:0] clkOut;
    logic [NUM_CH-1:0] tick;
    logic [NUM_PH-1:0] phaseOut;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mCnt   [NUM_CH];
    int mTicks [NUM_CH];
    int mDiv   [NUM_CH];
    logic [NUM_CH-1:0] mTick;

    phase_clock_divider #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .NUM_PH (NUM_PH)
    ) dut (
        .clkIn    (clkIn),
        .reset    (reset),
        .enable   (enable),
        .divVal   (divVal),
        .clkOut   (clkOut),
        .tick     (tick),
        .phaseOut (phaseOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    function automatic logic [DV_W-1:0] dv(input int a, input int b, input int c);
        return {CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    endfunction

    function automatic int effDiv(input logic [DV_W-1:0] v, input int ch);
        int d;
        d = int'(v[ch*CNT_W +: CNT_W]);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge
    task automatic modelStep(input logic r, input logic e, input logic [DV_W-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            int d;
            if (r) begin
                mCnt[i]   = 0;
                mTicks[i] = 0;
                mTick[i]  = 1'b0;
                mDiv[i]   = effDiv(v, i);
            end else begin
`ifdef PHASE_DIV_SHADOW_LOAD_EN
                d = mDiv[i];
`else
                d = effDiv(v, i);
`endif
                if (e && (mCnt[i] + 1 >= d)) begin
                    mCnt[i]   = 0;
                    mTicks[i] = mTicks[i] + 1;
                    mTick[i]  = 1'b1;
                    mDiv[i]   = effDiv(v, i);
                end else begin
                    if (e) mCnt[i] = mCnt[i] + 1;
                    mTick[i] = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model
    task automatic doEdge(input logic r, input logic e, input logic [DV_W-1:0] v);
        logic [NUM_CH-1:0] expClk;
        logic [NUM_PH-1:0] expPh;
        @(negedge clkIn);
        reset  = r;
        enable = e;
        divVal = v;
        @(posedge clkIn);
        modelStep(r, e, v);
        #1;
        for (int i = 0; i < NUM_CH; i++) expClk[i] = mTicks[i][0];
        expPh = NUM_PH'(1) << (mTicks[0] % NUM_PH);
        check("model_tick",   32'(tick),     32'(mTick));
        check("model_clkOut", 32'(clkOut),   32'(expClk));
        check("model_phase",  32'(phaseOut), 32'(expPh));
    endtask

    initial begin
        logic [DV_W-1:0] rv;
        logic            re;
        logic            rr;
        reset  = 1'b1;
        enable = 1'b0;
        divVal = '0;

        // Reset state and basic divide ratios 3 / 1 / 4
        doEdge(1'b1, 1'b1, dv(3, 1, 4));
        check("rst_tick",   32'(tick),     32'h0);
        check("rst_clkOut", 32'(clkOut),   32'h0);
        check("rst_phase",  32'(phaseOut), 32'h1);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e1_tick", 32'(tick), 32'b010);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e2_tick", 32'(tick), 32'b010);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e3_tick",  32'(tick),     32'b011);
        check("r025_e3_clk0",  32'(clkOut[0]), 32'h1);
        check("r025_e3_phase", 32'(phaseOut), 32'b0010);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e4_tick", 32'(tick), 32'b110);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e6_clk0", 32'(clkOut[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        doEdge(1'b0, 1'b1, dv(3, 1, 4));
        check("r025_e8_clk2", 32'(clkOut[2]), 32'h0);

        // Phase rotation with ch0 divisor 2
        doEdge(1'b1, 1'b0, dv(2, 1, 1));
        for (int k = 1; k <= 8; k++) begin
            doEdge(1'b0, 1'b1, dv(2, 1, 1));
            check("r026_phase", 32'(phaseOut), 32'(NUM_PH'(1) << ((k / 2) % NUM_PH)));
        end

        // Enable gap at cnt0 = 1 with divisor 3
        doEdge(1'b1, 1'b0, dv(3, 2, 2));
        doEdge(1'b0, 1'b1, dv(3, 2, 2));
        for (int k = 0; k < 5; k++) begin
            doEdge(1'b0, 1'b0, dv(3, 2, 2));
            check("r027_hold_tick0", 32'(tick[0]),   32'h0);
            check("r027_hold_clk0",  32'(clkOut[0]), 32'h0);
            check("r027_hold_phase", 32'(phaseOut),  32'h1);
        end
        doEdge(1'b0, 1'b1, dv(3, 2, 2));
        check("r027_resume1_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(3, 2, 2));
        check("r027_resume2_tick0", 32'(tick[0]), 32'h1);

        // Divisor shrink 8 -> 2 at cnt0 = 5
        doEdge(1'b1, 1'b0, dv(8, 3, 3));
        for (int k = 0; k < 5; k++) doEdge(1'b0, 1'b1, dv(8, 3, 3));
`ifdef PHASE_DIV_SHADOW_LOAD_EN
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_s1_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_s2_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_s3_tick0", 32'(tick[0]), 32'h1);
`else
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_n1_tick0", 32'(tick[0]), 32'h1);
`endif
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_next_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(2, 3, 3));
        check("r028_after_tick0", 32'(tick[0]), 32'h1);

        // Reset pulse mid-period, then restart latency
        doEdge(1'b1, 1'b0, dv(3, 5, 2));
        for (int k = 0; k < 4; k++) doEdge(1'b0, 1'b1, dv(3, 5, 2));
        doEdge(1'b1, 1'b1, dv(3, 5, 2));
        check("r029_rst_tick",   32'(tick),     32'h0);
        check("r029_rst_clkOut", 32'(clkOut),   32'h0);
        check("r029_rst_phase",  32'(phaseOut), 32'h1);
        doEdge(1'b0, 1'b1, dv(3, 5, 2));
        check("r029_e1_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(3, 5, 2));
        check("r029_e2_tick0", 32'(tick[0]), 32'h0);
        doEdge(1'b0, 1'b1, dv(3, 5, 2));
        check("r029_e3_tick0", 32'(tick[0]), 32'h1);

        // Divisor 0 acts as 1
        doEdge(1'b1, 1'b0, dv(0, 0, 2));
        doEdge(1'b0, 1'b1, dv(0, 0, 2));
        check("r030_e1_tick", 32'(tick[1:0]), 32'b11);
        check("r030_e1_clk0", 32'(clkOut[0]), 32'h1);
        doEdge(1'b0, 1'b1, dv(0, 0, 2));
        check("r030_e2_tick0", 32'(tick[0]), 32'h1);
        check("r030_e2_clk0",  32'(clkOut[0]), 32'h0);

        // Randomized traffic against the model
        rv = dv(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        doEdge(1'b1, 1'b0, rv);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0)
                rv = dv(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            re = ($urandom_range(0, 99) < 85);
            rr = ($urandom_range(0, 59) == 0);
            doEdge(rr, re, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
